// File: rtl/maze_player_mover.sv
// Player position tracker for the maze: picks a direction from the buttons, checks the
// per-cell constraint maps and grid edges, then steps or bumps. Also tracks step count and goal arrival.
module maze_player_mover #(
    parameter int size_y     = 20,
    parameter int size_x     = 40,
    parameter int XW         = 6,
    parameter int YW         = 5,
    parameter int START_X    = 0,
    parameter int START_Y    = 0,
    parameter int GOAL_X     = 39,
    parameter int GOAL_Y     = 19,
    parameter int MOVE_DELAY = 25000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [0:size_x-1] up_constraint    [size_y-1:0],
    input  logic [0:size_x-1] down_constraint  [size_y-1:0],
    input  logic [0:size_x-1] left_constraint  [size_y-1:0],
    input  logic [0:size_x-1] right_constraint [size_y-1:0],
    input  logic              start,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_left,
    input  logic              btn_right,
    output logic [XW-1:0]     pos_x,
    output logic [YW-1:0]     pos_y,
    output logic              moved,
    output logic              bumped,
    output logic              won,
    output logic              playing,
    output logic [15:0]       step_count
);

    // Handshake: none. Buttons are levels sampled every cycle; moved/bumped are
    // single-cycle pulses that appear the cycle after the step is triggered.

    typedef enum logic [1:0] {IDLE, PLAY, WON} state_t;

    localparam int DW = (MOVE_DELAY > 2) ? $clog2(MOVE_DELAY) : 1;
    localparam logic [DW-1:0] DLY_LAST = DW'(MOVE_DELAY - 1);
    localparam logic [XW-1:0] SPAWN_X  = XW'(START_X);
    localparam logic [YW-1:0] SPAWN_Y  = YW'(START_Y);
    localparam logic [XW-1:0] GOAL_XP  = XW'(GOAL_X);
    localparam logic [YW-1:0] GOAL_YP  = YW'(GOAL_Y);
    localparam logic [XW-1:0] X_MAX    = XW'(size_x - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(size_y - 1);

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    state_t          state, state_next;
    logic [3:0]      dir, prev_dir;
    logic [DW-1:0]   delay_cnt;
    logic            held, new_press, repeat_hit, trigger;
    logic            blocked;
    logic [XW-1:0]   tgt_x;
    logic [YW-1:0]   tgt_y;

    assign playing = (state == PLAY);
    assign won     = (state == WON);

    // start masks the buttons so a respawn never coincides with a step
    always_comb begin
        dir = DIR_NONE;
        if (state == PLAY && !start) begin
            if (btn_up)         dir = DIR_UP;
            else if (btn_down)  dir = DIR_DOWN;
            else if (btn_left)  dir = DIR_LEFT;
            else if (btn_right) dir = DIR_RIGHT;
        end
    end

    assign held       = (dir != DIR_NONE) && (dir == prev_dir);
    assign new_press  = (dir != DIR_NONE) && (dir != prev_dir);
    assign repeat_hit = held && (delay_cnt == DLY_LAST);
    assign trigger    = new_press || repeat_hit;

    // Grid edge takes precedence over the map so a stale 0 bit can never wrap the player
    always_comb begin
        blocked = 1'b0;
        tgt_x   = pos_x;
        tgt_y   = pos_y;
        case (dir)
            DIR_UP: begin
                blocked = (pos_y == '0) || up_constraint[pos_y][pos_x];
                tgt_y   = pos_y - YW'(1);
            end
            DIR_DOWN: begin
                blocked = (pos_y == Y_MAX) || down_constraint[pos_y][pos_x];
                tgt_y   = pos_y + YW'(1);
            end
            DIR_LEFT: begin
                blocked = (pos_x == '0) || left_constraint[pos_y][pos_x];
                tgt_x   = pos_x - XW'(1);
            end
            DIR_RIGHT: begin
                blocked = (pos_x == X_MAX) || right_constraint[pos_y][pos_x];
                tgt_x   = pos_x + XW'(1);
            end
            default: begin
                blocked = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = PLAY;
            PLAY: begin
                if (start)                                      state_next = PLAY;
                else if (pos_x == GOAL_XP && pos_y == GOAL_YP)  state_next = WON;
            end
            WON:  if (start) state_next = PLAY;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x      <= SPAWN_X;
            pos_y      <= SPAWN_Y;
            step_count <= '0;
            moved      <= 1'b0;
            bumped     <= 1'b0;
            delay_cnt  <= '0;
            prev_dir   <= DIR_NONE;
        end else begin
            moved  <= 1'b0;
            bumped <= 1'b0;
            if (start) begin
                pos_x      <= SPAWN_X;
                pos_y      <= SPAWN_Y;
                step_count <= '0;
                delay_cnt  <= '0;
                prev_dir   <= DIR_NONE;
            end else begin
                prev_dir <= dir;
                if (!held || repeat_hit) delay_cnt <= '0;
                else                     delay_cnt <= delay_cnt + DW'(1);
                if (trigger) begin
                    if (blocked) begin
                        bumped <= 1'b1;
                    end else begin
                        pos_x <= tgt_x;
                        pos_y <= tgt_y;
                        moved <= 1'b1;
                        if (step_count != 16'hFFFF) step_count <= step_count + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_maze_player_mover.sv
// Directed bench for maze_player_mover: short delay and a goal at (2,0) so every
// behaviour (stepping, bumping, repeat, priority, winning, async reset) fits one run.
module tb_maze_player_mover;

    localparam int SY = 20;
    localparam int SX = 40;
    localparam int XW = 6;
    localparam int YW = 5;

    logic            clk;
    logic            rst_n;
    logic [0:SX-1]   up_c    [SY-1:0];
    logic [0:SX-1]   down_c  [SY-1:0];
    logic [0:SX-1]   left_c  [SY-1:0];
    logic [0:SX-1]   right_c [SY-1:0];
    logic            start;
    logic            btn_up, btn_down, btn_left, btn_right;
    logic [XW-1:0]   pos_x;
    logic [YW-1:0]   pos_y;
    logic            moved, bumped, won, playing;
    logic [15:0]     step_count;

    int total = 0;
    int bad   = 0;
    int pulses;

    maze_player_mover #(
        .size_y(SY), .size_x(SX), .XW(XW), .YW(YW),
        .START_X(0), .START_Y(0), .GOAL_X(2), .GOAL_Y(0), .MOVE_DELAY(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .up_constraint(up_c), .down_constraint(down_c),
        .left_constraint(left_c), .right_constraint(right_c),
        .start(start),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .pos_x(pos_x), .pos_y(pos_y),
        .moved(moved), .bumped(bumped), .won(won), .playing(playing),
        .step_count(step_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // dir: 0=up 1=down 2=left 3=right; press one cycle, release one cycle
    task automatic step(input int d);
        btn_up    = (d == 0);
        btn_down  = (d == 1);
        btn_left  = (d == 2);
        btn_right = (d == 3);
        tick();
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        for (int r = 0; r < SY; r++) begin
            up_c[r] = '0; down_c[r] = '0; left_c[r] = '0; right_c[r] = '0;
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: reset state, buttons ignored in IDLE
        check("rst_pos_x", pos_x, 0);
        check("rst_pos_y", pos_y, 0);
        check("rst_won", won, 0);
        check("rst_playing", playing, 0);
        check("rst_count", step_count, 0);
        btn_right = 1'b1;
        tick();
        check("idle_no_move", moved, 0);
        check("idle_pos_x", pos_x, 0);
        btn_right = 1'b0;
        tick();

        // 2: accepted step, then blocked by the map
        pulse_start();
        check("start_playing", playing, 1);
        btn_right = 1'b1;
        tick();
        check("step_moved", moved, 1);
        check("step_bumped", bumped, 0);
        check("step_pos_x", pos_x, 1);
        check("step_count1", step_count, 1);
        btn_right = 1'b0;
        tick();
        check("moved_one_cycle", moved, 0);
        right_c[0][1] = 1'b1;
        btn_right = 1'b1;
        tick();
        check("map_bumped", bumped, 1);
        check("map_no_move", moved, 0);
        check("map_pos_x", pos_x, 1);
        check("map_count", step_count, 1);
        btn_right = 1'b0;
        tick();
        check("bumped_one_cycle", bumped, 0);
        right_c[0][1] = 1'b0;

        // 3: held button repeats every 4 cycles
        pulse_start();
        check("respawn_x", pos_x, 0);
        check("respawn_count", step_count, 0);
        pulses = 0;
        btn_down = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (moved) pulses++;
            if (i == 1) check("hold_first_y", pos_y, 1);
            if (i == 4) check("hold_wait_y", pos_y, 1);
            if (i == 5) check("hold_repeat_y", pos_y, 2);
        end
        btn_down = 1'b0;
        tick();
        check("hold_pulses", pulses, 3);
        check("hold_pos_y", pos_y, 3);
        check("hold_count", step_count, 3);

        // 4: walk to (5,5), priority up over left, left edge, row-indexed map bit
        step(1); step(1);
        for (int i = 0; i < 5; i++) step(3);
        check("walk_x", pos_x, 5);
        check("walk_y", pos_y, 5);
        btn_up = 1'b1; btn_left = 1'b1;
        tick();
        check("prio_x", pos_x, 5);
        check("prio_y", pos_y, 4);
        btn_up = 1'b0; btn_left = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) step(2);
        check("left_walk_x", pos_x, 0);
        btn_left = 1'b1;
        tick();
        check("edge_bumped", bumped, 1);
        check("edge_moved", moved, 0);
        check("edge_x", pos_x, 0);
        btn_left = 1'b0;
        tick();
        down_c[4][0] = 1'b1;
        btn_down = 1'b1;
        tick();
        check("down_map_bumped", bumped, 1);
        check("down_map_y", pos_y, 4);
        btn_down = 1'b0;
        tick();
        down_c[4][0] = 1'b0;
        check("walk_count", step_count, 16);

        // 5: reach goal (2,0)
        pulse_start();
        step(3);
        btn_right = 1'b1;
        tick();
        check("goal_moved", moved, 1);
        check("goal_x", pos_x, 2);
        check("goal_not_yet_won", won, 0);
        btn_right = 1'b0;
        tick();
        check("goal_won", won, 1);
        check("goal_not_playing", playing, 0);
        btn_down = 1'b1;
        tick();
        check("won_no_move", moved, 0);
        check("won_no_bump", bumped, 0);
        check("won_pos_y", pos_y, 0);
        check("won_count", step_count, 2);
        btn_down = 1'b0;
        tick();
        check("won_sticky", won, 1);
        pulse_start();
        check("restart_x", pos_x, 0);
        check("restart_count", step_count, 0);
        check("restart_playing", playing, 1);
        check("restart_won", won, 0);

        // 6: async reset mid-hold at (3,2)
        step(1); step(1);
        for (int i = 0; i < 3; i++) step(3);
        check("pre_rst_x", pos_x, 3);
        check("pre_rst_y", pos_y, 2);
        check("pre_rst_count", step_count, 5);
        up_c[2][3] = 1'b1;
        btn_up = 1'b1;
        tick();
        check("pre_rst_bumped", bumped, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_x", pos_x, 0);
        check("arst_y", pos_y, 0);
        check("arst_bumped", bumped, 0);
        check("arst_count", step_count, 0);
        check("arst_playing", playing, 0);
        btn_up = 1'b0;
        up_c[2][3] = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", playing, 0);
        check("post_rst_won", won, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
